// File: rtl/id_ex_reg_pkg.sv
// Shared RV32I ID/EX definitions: control-bundle layout, field widths,
// NOP constants and the per-edge register action decode.
package id_ex_reg_pkg;

  localparam int CTRL_W     = 7;
  localparam int ALU_OP_W   = 4;
  localparam int FUNCT3_W   = 3;
  localparam int REG_IDX_W  = 5;

  // Bit positions inside the control bundle, MSB first as presented by ID.
  localparam int CTRL_REG_WRITE = 6;
  localparam int CTRL_MEM_READ  = 5;
  localparam int CTRL_MEM_WRITE = 4;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC   = 2;
  localparam int CTRL_BRANCH    = 1;
  localparam int CTRL_JUMP      = 0;

  localparam logic [CTRL_W-1:0]    NOP_CTRL   = '0;
  localparam logic [ALU_OP_W-1:0]  NOP_ALU_OP = '0;
  localparam logic [FUNCT3_W-1:0]  NOP_FUNCT3 = '0;
  localparam logic [REG_IDX_W-1:0] NOP_REG    = '0;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic [FUNCT3_W-1:0]  funct3;
    logic [ALU_OP_W-1:0]  alu_op;
    logic [CTRL_W-1:0]    ctrl;
  } ex_fields_t;

  localparam ex_fields_t NOP_FIELDS = '{
    valid:  1'b0,
    rs1:    NOP_REG,
    rs2:    NOP_REG,
    rd:     NOP_REG,
    funct3: NOP_FUNCT3,
    alu_op: NOP_ALU_OP,
    ctrl:   NOP_CTRL
  };

  typedef enum logic [1:0] {
    ACT_LOAD      = 2'd0,
    ACT_HOLD      = 2'd1,
    ACT_NOP_COUNT = 2'd2,
    ACT_NOP_QUIET = 2'd3
  } reg_action_t;

  // A taken branch beats a memory wait; an empty ID slot is not a hazard
  // bubble, so it loads a NOP without touching the performance counter.
  function automatic reg_action_t select_action(
    input logic flush,
    input logic stall,
    input logic bubble,
    input logic id_valid
  );
    reg_action_t act;
    if (flush)         act = ACT_NOP_COUNT;
    else if (stall)    act = ACT_HOLD;
    else if (bubble)   act = ACT_NOP_COUNT;
    else if (!id_valid) act = ACT_NOP_QUIET;
    else               act = ACT_LOAD;
    return act;
  endfunction

endpackage

// File: rtl/id_ex_bypass.sv
// WB->ID write-through operand select for one register source.
// Register x0 is never bypassed since its value is hardwired to zero.
module id_ex_bypass
  import id_ex_reg_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [XLEN-1:0]      rf_data,
  input  logic                 wb_reg_write,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic [XLEN-1:0]      data
);

  logic hit;

  always_comb begin
    hit  = wb_reg_write && (wb_rd != NOP_REG) && (wb_rd == rs);
    data = (WB_BYPASS && hit) ? wb_data : rf_data;
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core with stall, flush,
// load-use bubble insertion, WB write-through and a saturating bubble counter.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 bubble,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic [FUNCT3_W-1:0]  id_funct3,
  input  logic [ALU_OP_W-1:0]  id_alu_op,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 wb_reg_write,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_rs1_data,
  output logic [XLEN-1:0]      ex_rs2_data,
  output logic [XLEN-1:0]      ex_imm,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [FUNCT3_W-1:0]  ex_funct3,
  output logic [ALU_OP_W-1:0]  ex_alu_op,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic [CNT_W-1:0]     bubble_cnt
);

  reg_action_t     action;
  ex_fields_t      id_fields;
  ex_fields_t      ex_fields;
  logic [XLEN-1:0] rs1_sel;
  logic [XLEN-1:0] rs2_sel;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [CNT_W-1:0] cnt_q;

  id_ex_bypass #(.XLEN(XLEN), .WB_BYPASS(WB_BYPASS)) u_bypass_rs1 (
    .rs           (id_rs1),
    .rf_data      (id_rs1_data),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .data         (rs1_sel)
  );

  id_ex_bypass #(.XLEN(XLEN), .WB_BYPASS(WB_BYPASS)) u_bypass_rs2 (
    .rs           (id_rs2),
    .rf_data      (id_rs2_data),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .data         (rs2_sel)
  );

  always_comb begin
    action           = select_action(flush, stall, bubble, id_valid);
    id_fields        = NOP_FIELDS;
    id_fields.valid  = 1'b1;
    id_fields.rs1    = id_rs1;
    id_fields.rs2    = id_rs2;
    id_fields.rd     = id_rd;
    id_fields.funct3 = id_funct3;
    id_fields.alu_op = id_alu_op;
    id_fields.ctrl   = id_ctrl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_fields  <= NOP_FIELDS;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      unique case (action)
        ACT_LOAD: begin
          ex_fields  <= id_fields;
          pc_q       <= id_pc;
          rs1_data_q <= rs1_sel;
          rs2_data_q <= rs2_sel;
          imm_q      <= id_imm;
        end
        ACT_HOLD: begin
          ex_fields  <= ex_fields;
          pc_q       <= pc_q;
          rs1_data_q <= rs1_data_q;
          rs2_data_q <= rs2_data_q;
          imm_q      <= imm_q;
        end
        default: begin
          ex_fields  <= NOP_FIELDS;
          pc_q       <= '0;
          rs1_data_q <= '0;
          rs2_data_q <= '0;
          imm_q      <= '0;
        end
      endcase
    end
  end

  // Performance counter survives flushes; it only clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((action == ACT_NOP_COUNT) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    ex_valid    = ex_fields.valid;
    ex_rs1      = ex_fields.rs1;
    ex_rs2      = ex_fields.rs2;
    ex_rd       = ex_fields.rd;
    ex_funct3   = ex_fields.funct3;
    ex_alu_op   = ex_fields.alu_op;
    ex_ctrl     = ex_fields.ctrl;
    ex_pc       = pc_q;
    ex_rs1_data = rs1_data_q;
    ex_rs2_data = rs2_data_q;
    ex_imm      = imm_q;
    bubble_cnt  = cnt_q;
  end

endmodule
